stream_topk_select: RTL

// - Downstream consumer of the localizer parallel-to-serial stage. Accepts the serial (value, index) beat stream.
// - Keeps the K smallest values of each frame, with their source indices, sorted ascending.
// - Publishes the sorted list once per frame so the localizer can pick the nearest sensor hits.
// - Frames are FRAME_LEN beats long and delimited by in_sof.

---
 rtl/localizer_pkg.sv | 20 ++
 rtl/topk_insert_cell.sv | 68 ++++++
 rtl/stream_topk_select.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/localizer_pkg.sv
// Shared types and constants for the localizer top-K selection path.
package localizer_pkg;

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] IDX_PAD = 4'hF;
    localparam int DW_DEF = 32;
    localparam logic [DW_DEF-1:0] DATA_PAD = '1;

    typedef struct packed {
        logic [DW_DEF-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              occ;
    } topk_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/topk_insert_cell.sv
// One slot of the sorted top-K list: loads the new beat, shifts in its upper neighbour, or holds.
module topk_insert_cell
    import localizer_pkg::*;
#(
    parameter int DW    = 32,
    parameter bit FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             ins,
    input  logic [DW-1:0]    in_data,
    input  logic [IDX_W-1:0] in_index,
    input  logic             prev_take,
    input  logic [DW-1:0]    up_data,
    input  logic [IDX_W-1:0] up_idx,
    input  logic             up_occ,
    output logic             take,
    output logic [DW-1:0]    data,
    output logic [IDX_W-1:0] idx,
    output logic             occ,
    output logic [DW-1:0]    nxt_data,
    output logic [IDX_W-1:0] nxt_idx,
    output logic             nxt_occ
);

    // Strict less-than keeps equal values behind the earlier beat; emptiness is the flag, not the value.
    assign take = !occ || (in_data < data);

    always_comb begin
        nxt_data = data;
        nxt_idx  = idx;
        nxt_occ  = occ;
        if (start) begin
            nxt_data = '1;
            nxt_idx  = IDX_PAD;
            nxt_occ  = 1'b0;
            if (FIRST && ins) begin
                nxt_data = in_data;
                nxt_idx  = in_index;
                nxt_occ  = 1'b1;
            end
        end else if (ins) begin
            if (prev_take) begin
                nxt_data = up_data;
                nxt_idx  = up_idx;
                nxt_occ  = up_occ;
            end else if (take) begin
                nxt_data = in_data;
                nxt_idx  = in_index;
                nxt_occ  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data <= '1;
            idx  <= IDX_PAD;
            occ  <= 1'b0;
        end else begin
            data <= nxt_data;
            idx  <= nxt_idx;
            occ  <= nxt_occ;
        end
    end

endmodule

// File: rtl/stream_topk_select.sv
// Keeps the K smallest (value, index) beats of each frame, sorted ascending, and publishes them per frame.
// state | meaning
// IDLE  | no frame open; only an sof beat starts one
// ACCUM | frame open; beat_cnt holds beats accepted so far
module stream_topk_select
    import localizer_pkg::*;
#(
    parameter int DW        = 32,
    parameter int FRAME_LEN = 12,
    parameter int K         = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [DW-1:0]          in_data,
    input  logic [IDX_W-1:0]       in_index,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data  [K],
    output logic [IDX_W-1:0]       out_index [K],
    output logic [$clog2(K+1)-1:0] out_count
);

    localparam int CW    = $clog2(FRAME_LEN + 1);
    localparam int CNT_W = $clog2(K + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic          start, ins, done;

    logic [K-1:0]     take;
    logic [K-1:0]     prev_take;
    logic [DW-1:0]    cur_data [K];
    logic [IDX_W-1:0] cur_idx  [K];
    logic [K-1:0]     cur_occ;
    logic [DW-1:0]    up_data  [K];
    logic [IDX_W-1:0] up_idx   [K];
    logic [K-1:0]     up_occ;
    logic [DW-1:0]    nxt_data [K];
    logic [IDX_W-1:0] nxt_idx  [K];
    logic [K-1:0]     nxt_occ;
    logic [CNT_W-1:0] nxt_count;

    // Padding beats advance the frame but never reach the list.
    assign start = in_valid && in_sof;
    assign ins   = in_valid && (in_index != IDX_PAD) && (in_sof || (state == ACCUM));

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        done         = 1'b0;
        if (start) begin
            state_nxt    = ACCUM;
            beat_cnt_nxt = CW'(1);
        end else if (in_valid && (state == ACCUM)) begin
            beat_cnt_nxt = beat_cnt + CW'(1);
        end
        if ((state_nxt == ACCUM) && (beat_cnt_nxt == CW'(FRAME_LEN))) begin
            done         = 1'b1;
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_cell
        if (i == 0) begin : g_head
            assign prev_take[i] = 1'b0;
            assign up_data[i]   = '1;
            assign up_idx[i]    = IDX_PAD;
            assign up_occ[i]    = 1'b0;
        end else begin : g_link
            assign prev_take[i] = take[i-1];
            assign up_data[i]   = cur_data[i-1];
            assign up_idx[i]    = cur_idx[i-1];
            assign up_occ[i]    = cur_occ[i-1];
        end

        topk_insert_cell #(
            .DW    (DW),
            .FIRST (i == 0)
        ) u_cell (
            .clk       (clk),
            .rstn      (rstn),
            .start     (start),
            .ins       (ins),
            .in_data   (in_data),
            .in_index  (in_index),
            .prev_take (prev_take[i]),
            .up_data   (up_data[i]),
            .up_idx    (up_idx[i]),
            .up_occ    (up_occ[i]),
            .take      (take[i]),
            .data      (cur_data[i]),
            .idx       (cur_idx[i]),
            .occ       (cur_occ[i]),
            .nxt_data  (nxt_data[i]),
            .nxt_idx   (nxt_idx[i]),
            .nxt_occ   (nxt_occ[i])
        );
    end

    always_comb begin
        nxt_count = '0;
        for (int i = 0; i < K; i++) begin
            nxt_count = nxt_count + CNT_W'(nxt_occ[i]);
        end
    end

    // The bank samples the list's next value so the final beat lands with one cycle of latency.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_count <= '0;
            for (int i = 0; i < K; i++) begin
                out_data[i]  <= '1;
                out_index[i] <= IDX_PAD;
            end
        end else begin
            out_valid <= done;
            if (done) begin
                out_count <= nxt_count;
                for (int i = 0; i < K; i++) begin
                    out_data[i]  <= nxt_data[i];
                    out_index[i] <= nxt_idx[i];
                end
            end
        end
    end

endmodule
